// File: rtl/load_align_unit_pkg.sv
// rtl/load_align_unit_pkg.sv - load encodings, FSM states and size decode for the load align unit
package load_align_unit_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        RESP = 2'd3
    } state_e;

    // Access size in bytes; zero marks an encoding that is illegal for this XLEN.
    function automatic logic [3:0] load_size(input logic [2:0] func3, input logic rv64);
        logic [3:0] size;
        case (func3)
            LB, LBU: size = 4'd1;
            LH, LHU: size = 4'd2;
            LW:      size = 4'd4;
            LWU:     size = rv64 ? 4'd4 : 4'd0;
            LD:      size = rv64 ? 4'd8 : 4'd0;
            default: size = 4'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// rtl/load_align_unit_if.sv - request, memory and response signals of the load align unit
interface load_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_func3;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ack;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_data;
    logic              resp_fault;

    modport slave (
        input  req_valid, req_addr, req_func3, mem_rdata, mem_ack,
        output req_ready, mem_read, mem_addr, resp_valid, resp_data, resp_fault
    );

    modport master (
        output req_valid, req_addr, req_func3, mem_rdata, mem_ack,
        input  req_ready, mem_read, mem_addr, resp_valid, resp_data, resp_fault
    );
endinterface

// File: rtl/load_align_unit_extract.sv
// rtl/load_align_unit_extract.sv - combinational byte extraction and sign/zero extension of a load
module load_extract
    import load_align_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              hi_i,
    input  logic [XLEN-1:0]              lo_i,
    input  logic [$clog2(XLEN/8)-1:0]    offset_i,
    input  logic [2:0]                   func3_i,
    output logic [XLEN-1:0]              data_o
);

    logic [2*XLEN-1:0] shifted;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   mask;
    logic              sign;

    assign shifted = {hi_i, lo_i} >> {offset_i, 3'b000};
    assign raw     = shifted[XLEN-1:0];

    always_comb begin
        mask = '0;
        sign = 1'b0;
        case (func3_i)
            LB:  begin mask = XLEN'(8'hFF);          sign = raw[7];  end
            LBU: begin mask = XLEN'(8'hFF);          sign = 1'b0;    end
            LH:  begin mask = XLEN'(16'hFFFF);       sign = raw[15]; end
            LHU: begin mask = XLEN'(16'hFFFF);       sign = 1'b0;    end
            LW:  begin mask = XLEN'(32'hFFFF_FFFF);  sign = raw[31]; end
            LWU: begin mask = XLEN'(32'hFFFF_FFFF);  sign = 1'b0;    end
            LD:  begin mask = '1;                    sign = 1'b0;    end
            default: begin mask = '0;                sign = 1'b0;    end
        endcase
    end

    // A full-width mask leaves ~mask empty, so RV32 lw and RV64 ld pass through untouched.
    assign data_o = (raw & mask) | (sign ? ~mask : '0);

endmodule

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - issues one or two aligned reads per load and returns the extended result
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ALLOW_MISALIGNED = 1,
    parameter int ADDR_W           = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    load_align_unit_if.slave bus
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [2:0]        func3_q, func3_d;
    logic              cross_q, cross_d;
    logic              mem_read_q, mem_read_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              fault_q, fault_d;

    logic [3:0]        req_size;
    logic [OFF_W-1:0]  req_off;
    logic [ADDR_W-1:0] req_base;
    logic              req_illegal;
    logic              req_cross;
    logic [XLEN-1:0]   ext_lo;
    logic [XLEN-1:0]   ext_hi;
    logic [XLEN-1:0]   ext_data;

    assign req_size    = load_size(bus.req_func3, XLEN == 64);
    assign req_off     = bus.req_addr[OFF_W-1:0];
    assign req_base    = bus.req_addr & ~ADDR_W'(NB - 1);
    assign req_illegal = (req_size == 4'd0);
    assign req_cross   = (32'(req_off) + 32'(req_size)) > 32'(NB);

    // The word arriving this cycle is fed straight in so the result registers on the ack edge.
    assign ext_lo = (state_q == RD0) ? bus.mem_rdata : lo_q;
    assign ext_hi = (state_q == RD1) ? bus.mem_rdata : hi_q;

    load_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .hi_i     (ext_hi),
        .lo_i     (ext_lo),
        .offset_i (off_q),
        .func3_i  (func3_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            mem_addr_q <= '0;
            off_q      <= '0;
            func3_q    <= '0;
            cross_q    <= 1'b0;
            mem_read_q <= 1'b0;
            lo_q       <= '0;
            hi_q       <= '0;
            data_q     <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            mem_addr_q <= mem_addr_d;
            off_q      <= off_d;
            func3_q    <= func3_d;
            cross_q    <= cross_d;
            mem_read_q <= mem_read_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            data_q     <= data_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
        off_d      = off_q;
        func3_d    = func3_q;
        cross_d    = cross_q;
        mem_read_d = mem_read_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        data_d     = data_q;
        fault_d    = fault_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    base_d  = req_base;
                    off_d   = req_off;
                    func3_d = bus.req_func3;
                    cross_d = req_cross;
                    if (req_illegal || (req_cross && ALLOW_MISALIGNED == 0)) begin
                        state_d = RESP;
                        data_d  = '0;
                        fault_d = 1'b1;
                    end else begin
                        state_d    = RD0;
                        mem_read_d = 1'b1;
                        mem_addr_d = req_base;
                    end
                end
            end
            RD0: begin
                if (bus.mem_ack) begin
                    lo_d = bus.mem_rdata;
                    if (cross_q) begin
                        state_d    = RD1;
                        mem_addr_d = base_q + ADDR_W'(NB);
                    end else begin
                        state_d    = RESP;
                        mem_read_d = 1'b0;
                        data_d     = ext_data;
                        fault_d    = 1'b0;
                    end
                end
            end
            RD1: begin
                if (bus.mem_ack) begin
                    hi_d       = bus.mem_rdata;
                    state_d    = RESP;
                    mem_read_d = 1'b0;
                    data_d     = ext_data;
                    fault_d    = 1'b0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = data_q;
    assign bus.resp_fault = fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - directed bench for RV32 (split and fault variants) and RV64 load alignment
module tb_load_align_unit;
    import load_align_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_align_unit_if #(.XLEN(32), .ADDR_W(32)) ifa ();
    load_align_unit_if #(.XLEN(32), .ADDR_W(32)) ifb ();
    load_align_unit_if #(.XLEN(64), .ADDR_W(32)) ifc ();

    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1), .ADDR_W(32)) dut_a (
        .clk(clk), .reset_n(rst_n), .bus(ifa.slave));
    load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(0), .ADDR_W(32)) dut_b (
        .clk(clk), .reset_n(rst_n), .bus(ifb.slave));
    load_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1), .ADDR_W(32)) dut_c (
        .clk(clk), .reset_n(rst_n), .bus(ifc.slave));

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [63:0] mem_c [256];

    int checks = 0;
    int failures = 0;
    int wait_a = 0;
    int cnt_a = 0;
    int acks_a = 0;
    int rdcyc_b = 0;
    int acks_c = 0;
    int resp_cnt_a = 0;
    logic [31:0] addr_a [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memory models answer on the falling edge so the DUT sees a settled ack at its rising edge.
    always @(negedge clk) begin
        ifa.mem_ack = 1'b0;
        if (ifa.mem_read) begin
            if (cnt_a >= wait_a) begin
                ifa.mem_ack   = 1'b1;
                ifa.mem_rdata = mem_a[ifa.mem_addr[9:2]];
                acks_a++;
                addr_a.push_back(ifa.mem_addr);
                cnt_a = 0;
            end else begin
                cnt_a++;
            end
        end else begin
            cnt_a = 0;
        end
    end

    always @(negedge clk) begin
        ifb.mem_ack = 1'b0;
        if (ifb.mem_read) begin
            rdcyc_b++;
            ifb.mem_ack   = 1'b1;
            ifb.mem_rdata = mem_b[ifb.mem_addr[9:2]];
        end
    end

    always @(negedge clk) begin
        ifc.mem_ack = 1'b0;
        if (ifc.mem_read) begin
            acks_c++;
            ifc.mem_ack   = 1'b1;
            ifc.mem_rdata = mem_c[ifc.mem_addr[10:3]];
        end
    end

    always @(posedge clk) begin
        if (ifa.resp_valid) resp_cnt_a++;
    end

    task automatic run_load(input int sel, input logic [31:0] addr, input logic [2:0] f3,
                            output int lat, output logic [63:0] data, output logic fault);
        logic rv;
        logic rdy;
        bit   done;
        done  = 1'b0;
        lat   = -1;
        data  = '0;
        fault = 1'b0;
        @(negedge clk);
        #1;
        case (sel)
            0: begin ifa.req_valid = 1'b1; ifa.req_addr = addr; ifa.req_func3 = f3; rdy = ifa.req_ready; end
            1: begin ifb.req_valid = 1'b1; ifb.req_addr = addr; ifb.req_func3 = f3; rdy = ifb.req_ready; end
            default: begin ifc.req_valid = 1'b1; ifc.req_addr = addr; ifc.req_func3 = f3; rdy = ifc.req_ready; end
        endcase
        check("req_ready", {63'd0, rdy}, 64'd1);
        @(posedge clk);
        #1;
        ifa.req_valid = 1'b0;
        ifb.req_valid = 1'b0;
        ifc.req_valid = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            case (sel)
                0: rv = ifa.resp_valid;
                1: rv = ifb.resp_valid;
                default: rv = ifc.resp_valid;
            endcase
            if (rv) begin
                lat  = k + 1;
                done = 1'b1;
                case (sel)
                    0: begin data = {32'd0, ifa.resp_data}; fault = ifa.resp_fault; end
                    1: begin data = {32'd0, ifb.resp_data}; fault = ifb.resp_fault; end
                    default: begin data = ifc.resp_data; fault = ifc.resp_fault; end
                endcase
            end else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_req_ready"},  {63'd0, ifa.req_ready},  64'd1);
        check({tag, "_mem_read"},   {63'd0, ifa.mem_read},   64'd0);
        check({tag, "_mem_addr"},   {32'd0, ifa.mem_addr},   64'd0);
        check({tag, "_resp_valid"}, {63'd0, ifa.resp_valid}, 64'd0);
        check({tag, "_resp_data"},  {32'd0, ifa.resp_data},  64'd0);
        check({tag, "_resp_fault"}, {63'd0, ifa.resp_fault}, 64'd0);
    endtask

    int          lat;
    logic [63:0] d;
    logic        f;
    bit          seen;
    int          resp_before;

    initial begin
        ifa.req_valid = 1'b0; ifa.req_addr = '0; ifa.req_func3 = '0; ifa.mem_ack = 1'b0; ifa.mem_rdata = '0;
        ifb.req_valid = 1'b0; ifb.req_addr = '0; ifb.req_func3 = '0; ifb.mem_ack = 1'b0; ifb.mem_rdata = '0;
        ifc.req_valid = 1'b0; ifc.req_addr = '0; ifc.req_func3 = '0; ifc.mem_ack = 1'b0; ifc.mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
            mem_c[i] = '0;
        end
        mem_a[8'h40] = 32'h8765_43F1;
        mem_b[8'h40] = 32'h8765_43F1;
        mem_c[8'h40] = 64'h8000_0001_0000_0000;
        mem_c[8'h41] = 64'h1122_3344_5566_7788;

        repeat (3) @(posedge clk);
        #1;
        check_reset_a("reset");
        check("reset_c_resp_data", ifc.resp_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // RV32, misaligned loads split into two reads
        acks_a = 0; addr_a.delete();
        run_load(0, 32'h100, LB, lat, d, f);
        check("lb_100_data", d, 64'hFFFF_FFF1);
        check("lb_100_fault", {63'd0, f}, 64'd0);
        check("lb_100_lat", lat, 2);
        check("lb_100_reads", acks_a, 1);

        acks_a = 0; addr_a.delete();
        run_load(0, 32'h102, LHU, lat, d, f);
        check("lhu_102_data", d, 64'h0000_8765);
        check("lhu_102_reads", acks_a, 1);
        check("lhu_102_addr", (addr_a.size() > 0) ? {32'd0, addr_a[0]} : 64'hDEAD, 64'h100);
        check("lhu_102_lat", lat, 2);

        mem_a[8'h40] = 32'h4433_2211;
        mem_a[8'h41] = 32'h8877_6655;
        acks_a = 0; addr_a.delete();
        run_load(0, 32'h103, LW, lat, d, f);
        check("lw_103_data", d, 64'h7766_5544);
        check("lw_103_lat", lat, 3);
        check("lw_103_reads", acks_a, 2);
        check("lw_103_addr0", (addr_a.size() > 0) ? {32'd0, addr_a[0]} : 64'hDEAD, 64'h100);
        check("lw_103_addr1", (addr_a.size() > 1) ? {32'd0, addr_a[1]} : 64'hDEAD, 64'h104);

        run_load(0, 32'h103, LH, lat, d, f);
        check("lh_103_data", d, 64'h0000_5544);
        check("lh_103_lat", lat, 3);

        wait_a = 2;
        run_load(0, 32'h103, LB, lat, d, f);
        check("lb_103_wait_data", d, 64'h44);
        check("lb_103_wait_lat", lat, 4);
        wait_a = 0;

        acks_a = 0;
        run_load(0, 32'h100, LD, lat, d, f);
        check("ld_rv32_fault", {63'd0, f}, 64'd1);
        check("ld_rv32_data", d, 64'd0);
        check("ld_rv32_lat", lat, 1);
        check("ld_rv32_reads", acks_a, 0);

        // RV32, misaligned loads disallowed
        rdcyc_b = 0;
        run_load(1, 32'h103, LH, lat, d, f);
        check("b_lh_103_fault", {63'd0, f}, 64'd1);
        check("b_lh_103_data", d, 64'd0);
        check("b_lh_103_lat", lat, 1);
        check("b_lh_103_reads", rdcyc_b, 0);

        run_load(1, 32'h100, 3'b111, lat, d, f);
        check("b_f3_111_fault", {63'd0, f}, 64'd1);
        check("b_f3_111_lat", lat, 1);
        check("b_f3_111_reads", rdcyc_b, 0);

        run_load(1, 32'h100, LW, lat, d, f);
        check("b_lw_100_data", d, 64'h8765_43F1);
        check("b_lw_100_fault", {63'd0, f}, 64'd0);
        check("b_lw_100_lat", lat, 2);
        check("b_hold_data", {32'd0, ifb.resp_data}, 64'h8765_43F1);
        check("b_hold_valid", {63'd0, ifb.resp_valid}, 64'd0);

        // RV64
        run_load(2, 32'h204, LWU, lat, d, f);
        check("c_lwu_204", d, 64'h0000_0000_8000_0001);
        check("c_lwu_204_lat", lat, 2);
        run_load(2, 32'h204, LW, lat, d, f);
        check("c_lw_204", d, 64'hFFFF_FFFF_8000_0001);
        run_load(2, 32'h200, LD, lat, d, f);
        check("c_ld_200", d, 64'h8000_0001_0000_0000);
        acks_c = 0;
        run_load(2, 32'h204, LD, lat, d, f);
        check("c_ld_204", d, 64'h5566_7788_8000_0001);
        check("c_ld_204_lat", lat, 3);
        check("c_ld_204_reads", acks_c, 2);
        run_load(2, 32'h207, LBU, lat, d, f);
        check("c_lbu_207", d, 64'h80);
        run_load(2, 32'h207, LB, lat, d, f);
        check("c_lb_207", d, 64'hFFFF_FFFF_FFFF_FF80);

        // Reset pulled while the second read of a split load is waiting
        wait_a = 3;
        resp_before = resp_cnt_a;
        @(negedge clk);
        #1;
        ifa.req_valid = 1'b1; ifa.req_addr = 32'h103; ifa.req_func3 = LW;
        @(posedge clk);
        #1;
        ifa.req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (ifa.mem_read && ifa.mem_addr == 32'h104) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("rst_rd1_reached", {63'd0, seen}, 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_a("midrst");
        repeat (3) @(posedge clk);
        check("midrst_no_resp", resp_cnt_a, resp_before);
        @(negedge clk);
        rst_n = 1'b1;
        wait_a = 0;

        run_load(0, 32'h100, LB, lat, d, f);
        check("post_rst_lb_data", d, 64'h11);
        check("post_rst_lb_fault", {63'd0, f}, 64'd0);
        check("post_rst_lb_lat", lat, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised successor of the combinational load data extender. Sits between the MEM stage and the data memory/cache port.
- Accepts one load request (address + func3) at a time and issues one or two word-aligned memory reads. Two reads are needed when the access crosses a word boundary.
- Extracts the addressed bytes, sign- or zero-extends them to XLEN, and returns the result with a one-cycle valid pulse.
- Supports RV32 and RV64 load encodings. Illegal or disallowed accesses are flagged as faults.

Parameters:
- XLEN, 32, datapath and memory word width in bits; legal values are 32 or 64.
- ALLOW_MISALIGNED, 1, 1 = split boundary-crossing loads into two reads; 0 = report a fault instead.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  byte address.
- req_func3  in  3  RISC-V load func3.
- mem_read  out  1  memory read strobe; held until mem_ack.
- mem_addr  out  ADDR_W  word-aligned read address (low log2(XLEN/8) bits are 0).
- mem_rdata  in  XLEN  read data; valid when mem_ack is high.
- mem_ack  in  1  read completes this cycle.
- resp_valid  out  1  single-cycle pulse: result is ready.
- resp_data  out  XLEN  extended load result.
- resp_fault  out  1  qualifies resp_valid: illegal func3 or disallowed misaligned access.

Behaviour:
- Reset: state = IDLE; req_ready = 1; mem_read = 0; mem_addr = 0; resp_valid = 0; resp_data = 0; resp_fault = 0; internal buffers = 0. Reset asserted mid-operation abandons the access; no response is produced.
- Accept: req_valid && req_ready at edge T. Latch addr, func3, offset = addr[log2(XLEN/8)-1:0], and size.
- Size by func3:
  - 000 lb / 100 lbu: 1 byte.
  - 001 lh / 101 lhu: 2 bytes.
  - 010 lw: 4 bytes.
  - 110 lwu: 4 bytes, XLEN = 64 only.
  - 011 ld: 8 bytes, XLEN = 64 only.
  - 111, and 011/110 when XLEN = 32: illegal.
- Cross condition: cross = (offset + size > XLEN/8).
- State machine: IDLE -> RD0 -> [RD1] -> RESP -> IDLE.
  - IDLE: on accept, go to RESP with a fault if func3 is illegal, or if cross && !ALLOW_MISALIGNED. Otherwise go to RD0.
  - RD0: mem_read = 1, mem_addr = addr with offset bits cleared. On mem_ack, capture lo_buf = mem_rdata. Go to RD1 if cross, else RESP.
  - RD1: mem_read = 1, mem_addr = RD0 address + XLEN/8 (wraps modulo 2^ADDR_W). On mem_ack, capture hi_buf, go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle, then IDLE. No backpressure on the response.
  - Fault response: resp_fault = 1, resp_data = 0, no mem_read is ever issued.
- Extraction:
  - raw = ({hi_buf, lo_buf} >> (offset*8)), low size*8 bits.
  - Signed loads (lb, lh, lw on RV64) replicate the top bit of raw.
  - Unsigned loads zero-fill.
  - lw on RV32 and ld on RV64 pass raw through unchanged.
  - The result is registered into resp_data on entry to RESP.
- Latency:
  - Aligned access with mem_ack in its first RD0 cycle: resp_valid at T+2.
  - Crossing access: each mem_ack adds one state; minimum T+3.
  - Fault: resp_valid at T+1.
  - Memory wait states stretch RD0/RD1 indefinitely; mem_read and mem_addr stay stable throughout.
- req_ready = 0 outside IDLE; requests presented then are ignored.
- resp_data and resp_fault hold their value after the pulse until the next RESP.
- mem_ack arriving outside RD0/RD1 is ignored.

Decomposition:
- Shared package: func3 load-encoding constants (LB, LH, LW, LD, LBU, LHU, LWU) and the state enum (IDLE, RD0, RD1, RESP).
- One sub-module, load_extract: purely combinational; inputs {hi, lo}, offset, func3; output is the extended XLEN result. It is reusable by the store path and the cache refill path.

Test Plan:
- XLEN=32, memory word at 0x100 = 0x8765_43F1; lb from 0x100 -> resp_data = 0xFFFF_FFF1, fault = 0, resp_valid at T+2.
- Same word, lhu from 0x102 -> resp_data = 0x0000_8765; exactly one mem_read, mem_addr = 0x100.
- ALLOW_MISALIGNED=1, words 0x100 = 0x4433_2211 and 0x104 = 0x8877_6655; lw from 0x103 -> two reads (0x100, then 0x104), resp_data = 0x7766_5544.
- ALLOW_MISALIGNED=0, lh from 0x103 -> resp_fault = 1, resp_data = 0, no mem_read, resp_valid at T+1. Also func3 = 111 -> fault.
- XLEN=64, lwu from 0x204, dword at 0x200 = 0x8000_0001_0000_0000 -> resp_data = 0x0000_0000_8000_0001. Repeat with lw -> 0xFFFF_FFFF_8000_0001.
- Reset_n pulled low during RD1 with 3 mem wait cycles -> outputs return to reset values asynchronously, no resp_valid. A new request after release completes normally.
